// File: rtl/bist_pkg.sv
// Shared types for the BIST failure logger: run-state encoding and the logged failure entry.
package bist_pkg;
  localparam int BIST_ADDR_W = 8;
  localparam int BIST_ELEM_W = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} bist_state_e;

  typedef struct packed {
    logic [BIST_ADDR_W-1:0] addr;
    logic [BIST_ELEM_W-1:0] elem;
  } fail_entry_t;
endpackage

// File: rtl/bist_fail_fifo.sv
// Circular show-ahead buffer; the head is held in its own register so it keeps its last value when empty.
module bist_fail_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_N = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q, rd_nxt;
  logic [PW:0]   cnt_q, cnt_d;
  logic [W-1:0]  head_q;
  logic          push_ok, pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_N);
  assign head    = head_q;
  assign pop_ok  = pop && !empty;
  // A push into a full buffer is fine when the head leaves on the same edge.
  assign push_ok = push && (!full || pop_ok);
  assign rd_nxt  = rd_q + PW'(1);

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + PW'(1);
      if (pop_ok)  rd_q <= rd_nxt;
      cnt_q <= cnt_d;
      // Head follows the incoming entry only when it becomes the sole occupant.
      if (push_ok && (empty || (pop_ok && cnt_q == (PW+1)'(1))))
        head_q <= din;
      else if (pop_ok && cnt_q > (PW+1)'(1))
        head_q <= mem_q[rd_nxt];
    end
  end
endmodule

// File: rtl/bist_fail_logger.sv
// Counts comparator mismatches per BIST run, logs the first LOG_DEPTH of them, and reports run status.
module bist_fail_logger
  import bist_pkg::*;
#(
  parameter int ADDR_W    = BIST_ADDR_W,
  parameter int ELEM_W    = BIST_ELEM_W,
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_start,
  input  logic              test_done,
  input  logic              cmp_valid,
  input  logic              comp_out,
  input  logic [ADDR_W-1:0] cmp_addr,
  input  logic [ELEM_W-1:0] cmp_elem,
  input  logic              log_rd,
  output logic              log_valid,
  output logic [ADDR_W-1:0] log_addr,
  output logic [ELEM_W-1:0] log_elem,
  output logic [CNT_W-1:0]  fail_count,
  output logic              overflow,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  bist_state_e         st_q, st_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                fail_ev, log_full, log_empty, pop_ok;
  logic [ADDR_W+ELEM_W-1:0] head;

  // A compare landing on the test_start cycle belongs to the old run and is discarded.
  assign fail_ev = (st_q == RUN) && cmp_valid && comp_out && !test_start;
  assign pop_ok  = log_rd && !log_empty;

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:    if (test_start) st_d = RUN;
      RUN:     if (test_start) st_d = RUN;
               else if (test_done) st_d = DONE;
      DONE:    if (test_start) st_d = RUN;
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (test_start) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (fail_ev) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
      if (log_full && !pop_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  bist_fail_fifo #(.DEPTH(LOG_DEPTH), .W(ADDR_W+ELEM_W)) u_log (
    .clk  (clk),
    .rst  (rst),
    .flush(test_start),
    .push (fail_ev),
    .pop  (log_rd),
    .din  ({cmp_addr, cmp_elem}),
    .full (log_full),
    .empty(log_empty),
    .head (head)
  );

  assign log_valid  = !log_empty;
  assign log_addr   = head[ADDR_W+ELEM_W-1:ELEM_W];
  assign log_elem   = head[ELEM_W-1:0];
  assign fail_count = cnt_q;
  assign overflow   = ovf_q;
  assign busy       = (st_q == RUN);
  assign done       = (st_q == DONE);
  assign pass       = (st_q == DONE) && (cnt_q == '0);
endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed bench for bist_fail_logger; a second instance with a 4-bit counter shares the stimulus.
module tb_bist_fail_logger;
  import bist_pkg::*;

  logic clk = 1'b0;
  logic rst, test_start, test_done, cmp_valid, comp_out, log_rd;
  logic [7:0] cmp_addr;
  logic [2:0] cmp_elem;

  logic        log_valid, overflow, busy, done, pass;
  logic [7:0]  log_addr;
  logic [2:0]  log_elem;
  logic [11:0] fail_count;

  logic        s_log_valid, s_overflow, s_busy, s_done, s_pass;
  logic [7:0]  s_log_addr;
  logic [2:0]  s_log_elem;
  logic [3:0]  s_fail_count;

  int n_cmp = 0;
  int n_bad = 0;
  fail_entry_t ent;

  always #5 clk = ~clk;

  bist_fail_logger #(.ADDR_W(8), .ELEM_W(3), .LOG_DEPTH(8), .CNT_W(12)) dut (
    .clk(clk), .rst(rst), .test_start(test_start), .test_done(test_done),
    .cmp_valid(cmp_valid), .comp_out(comp_out), .cmp_addr(cmp_addr), .cmp_elem(cmp_elem),
    .log_rd(log_rd), .log_valid(log_valid), .log_addr(log_addr), .log_elem(log_elem),
    .fail_count(fail_count), .overflow(overflow), .busy(busy), .done(done), .pass(pass));

  bist_fail_logger #(.ADDR_W(8), .ELEM_W(3), .LOG_DEPTH(8), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .test_start(test_start), .test_done(test_done),
    .cmp_valid(cmp_valid), .comp_out(comp_out), .cmp_addr(cmp_addr), .cmp_elem(cmp_elem),
    .log_rd(log_rd), .log_valid(s_log_valid), .log_addr(s_log_addr), .log_elem(s_log_elem),
    .fail_count(s_fail_count), .overflow(s_overflow), .busy(s_busy), .done(s_done), .pass(s_pass));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start();
    test_start = 1'b1;
    step();
    test_start = 1'b0;
  endtask

  task automatic fail(input logic [7:0] a, input logic [2:0] e);
    cmp_valid = 1'b1; comp_out = 1'b1; cmp_addr = a; cmp_elem = e;
    step();
    cmp_valid = 1'b0; comp_out = 1'b0;
  endtask

  task automatic pop();
    log_rd = 1'b1;
    step();
    log_rd = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {31'd0, log_valid}, 32'd0);
    chk({tag, "_addr"}, {24'd0, log_addr}, 32'd0);
    chk({tag, "_elem"}, {29'd0, log_elem}, 32'd0);
    chk({tag, "_cnt"}, {20'd0, fail_count}, 32'd0);
    chk({tag, "_flags"}, {27'd0, overflow, busy, done, pass, s_log_valid}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; test_start = 1'b0; test_done = 1'b0; cmp_valid = 1'b0;
    comp_out = 1'b0; cmp_addr = '0; cmp_elem = '0; log_rd = 1'b0;
    step(); step();
    chk_zero("reset");
    rst = 1'b0;
    step();

    // Reset mid-run with three entries held.
    start();
    fail(8'h11, 3'd1); fail(8'h12, 3'd2); fail(8'h13, 3'd3);
    chk("mid_cnt", {20'd0, fail_count}, 32'd3);
    chk("mid_head", {24'd0, log_addr}, 32'h11);
    rst = 1'b1;
    step();
    chk_zero("mid_rst");
    rst = 1'b0;
    step();

    // Failures while idle are ignored.
    fail(8'h44, 3'd5);
    chk("idle_cnt", {20'd0, fail_count}, 32'd0);
    chk("idle_valid", {31'd0, log_valid}, 32'd0);

    // Basic run: two failures and one passing compare.
    start();
    chk("run_busy", {29'd0, busy, done, pass}, 32'b100);
    fail(8'h05, 3'd1);
    chk("lat_cnt", {20'd0, fail_count}, 32'd1);
    chk("lat_head", {20'd0, log_valid, log_addr, log_elem}, {20'd0, 1'b1, 8'h05, 3'd1});
    cmp_valid = 1'b1; comp_out = 1'b0; cmp_addr = 8'h06; cmp_elem = 3'd1;
    step();
    cmp_valid = 1'b0;
    fail(8'hFF, 3'd4);
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    chk("basic_cnt", {20'd0, fail_count}, 32'd2);
    chk("basic_stat", {29'd0, busy, done, pass}, 32'b010);
    chk("basic_h0", {20'd0, log_valid, log_addr, log_elem}, {20'd0, 1'b1, 8'h05, 3'd1});
    pop();
    ent = '{addr: 8'hFF, elem: 3'd4};
    chk("basic_h1", {20'd0, log_valid, log_addr, log_elem}, {20'd0, 1'b1, ent});
    pop();
    chk("basic_empty", {31'd0, log_valid}, 32'd0);
    chk("basic_hold", {24'd0, log_addr}, 32'hFF);

    // Ten failures overflow an eight-entry log.
    start();
    for (int i = 0; i < 10; i++) fail(8'(8'h10 + i), 3'(i));
    chk("ovf_cnt", {20'd0, fail_count}, 32'd10);
    chk("ovf_cnt4", {28'd0, s_fail_count}, 32'd10);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      ent = '{addr: 8'(8'h10 + i), elem: 3'(i)};
      chk($sformatf("ovf_e%0d", i), {20'd0, log_valid, log_addr, log_elem}, {20'd0, 1'b1, ent});
      pop();
    end
    chk("ovf_drained", {31'd0, log_valid}, 32'd0);

    // Full log with simultaneous push and pop.
    start();
    chk("fp_clr", {30'd0, overflow, log_valid}, 32'd0);
    for (int i = 0; i < 8; i++) fail(8'(8'h20 + i), 3'd2);
    log_rd = 1'b1;
    fail(8'h80, 3'd7);
    log_rd = 1'b0;
    chk("fp_ovf", {31'd0, overflow}, 32'd0);
    chk("fp_head", {24'd0, log_addr}, 32'h21);
    for (int i = 0; i < 7; i++) pop();
    chk("fp_last", {20'd0, log_valid, log_addr, log_elem}, {20'd0, 1'b1, 8'h80, 3'd7});
    pop();
    chk("fp_empty", {31'd0, log_valid}, 32'd0);

    // Saturation of the narrow counter.
    start();
    for (int i = 0; i < 20; i++) fail(8'(i), 3'd0);
    chk("sat_cnt12", {20'd0, fail_count}, 32'd20);
    chk("sat_cnt4", {28'd0, s_fail_count}, 32'd15);
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    fail(8'h99, 3'd1);
    chk("done_ignore", {20'd0, fail_count}, 32'd20);

    // Clean run over every address.
    start();
    for (int i = 0; i < 256; i++) begin
      cmp_valid = 1'b1; comp_out = 1'b0; cmp_addr = 8'(i); cmp_elem = 3'd3;
      step();
    end
    cmp_valid = 1'b0;
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    chk("clean_stat", {29'd0, busy, done, pass}, 32'b011);
    chk("clean_cnt", {20'd0, fail_count}, 32'd0);
    chk("clean_valid", {31'd0, log_valid}, 32'd0);
    start();
    chk("restart_stat", {29'd0, busy, done, pass}, 32'b100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
